// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction-fetch / load-store memory port arbiter.
// Optional watchdog is enabled with the MEM_ARB_TIMEOUT_EN macro.
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2,
        RESP    = 2'd3
    } state_e;

    // RV32 load/store funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic            fetch;
        logic [2:0]      ls_type;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store data replication,
// load extension and the misalign/illegal-type flag.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic            is_fetch_i,
    input  logic            we_i,
    input  logic [2:0]      type_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [BE_W-1:0] be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misalign_o
);

    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        off        = addr_i[1:0];
        byte_sel   = 8'(rdata_i >> {off, 3'b000});
        half_sel   = 16'(rdata_i >> {off[1], 4'b0000});
        be_o       = 4'hF;
        wdata_o    = '0;
        rdata_o    = '0;
        misalign_o = 1'b0;
        if (is_fetch_i) begin
            rdata_o    = rdata_i;
            misalign_o = (off != 2'b00);
        end else if (we_i) begin
            case (type_i)
                F3_SB: begin
                    be_o    = 4'b0001 << off;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                F3_SH: begin
                    be_o       = 4'b0011 << {off[1], 1'b0};
                    wdata_o    = {2{wdata_i[15:0]}};
                    misalign_o = off[0];
                end
                F3_SW: begin
                    wdata_o    = wdata_i;
                    misalign_o = (off != 2'b00);
                end
                default: misalign_o = 1'b1;
            endcase
        end else begin
            case (type_i)
                F3_LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
                F3_LBU: rdata_o = {24'h0, byte_sel};
                F3_LH: begin
                    rdata_o    = {{16{half_sel[15]}}, half_sel};
                    misalign_o = off[0];
                end
                F3_LHU: begin
                    rdata_o    = {16'h0, half_sel};
                    misalign_o = off[0];
                end
                F3_LW: begin
                    rdata_o    = rdata_i;
                    misalign_o = (off != 2'b00);
                end
                default: misalign_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one memory port.
// Define MEM_ARB_TIMEOUT_EN to add a BUSY watchdog of TIMEOUT_CYCLES cycles.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_valid,
    output logic            if_err,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [2:0]      ls_type,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic [XLEN-1:0] ls_rdata,
    output logic            ls_valid,
    output logic            ls_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [BE_W-1:0] mem_be,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            core_stall
);

    state_e          state_q, state_d;
    mem_cmd_t        cmd_q, cmd_d;
    logic            last_ls_q, last_ls_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            if_valid_q, if_valid_d, ls_valid_q, ls_valid_d;
    logic            if_err_q, if_err_d, ls_err_q, ls_err_d;

    logic            idle_c, busy_c, grant_if_c, grant_ls_c;
    logic            al_fetch, al_we, al_misalign;
    logic [2:0]      al_type;
    logic [XLEN-1:0] al_addr, al_wdata, al_rdata;
    logic [BE_W-1:0] al_be;

    assign idle_c     = (state_q == IDLE);
    assign busy_c     = (state_q == BUSY_IF) || (state_q == BUSY_LS);
    // On a tie the port not granted last wins; pointer resets to IF so LS goes first
    assign grant_ls_c = idle_c & ls_req & (~if_req | ~last_ls_q);
    assign grant_if_c = idle_c & if_req & ~grant_ls_c;

    // In IDLE the aligner sees the incoming request, otherwise the held one
    assign al_fetch = idle_c ? grant_if_c : cmd_q.fetch;
    assign al_we    = idle_c & grant_ls_c & ls_we;
    assign al_type  = idle_c ? ls_type : cmd_q.ls_type;
    assign al_addr  = idle_c ? (grant_if_c ? if_addr : ls_addr) : cmd_q.addr;

    mem_lane_align u_align (
        .is_fetch_i (al_fetch),
        .we_i       (al_we),
        .type_i     (al_type),
        .addr_i     (al_addr),
        .wdata_i    (ls_wdata),
        .rdata_i    (mem_rdata),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (al_misalign)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt_q;
    logic             timeout_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          wd_cnt_q <= '0;
        else if (!busy_c) wd_cnt_q <= '0;
        else              wd_cnt_q <= wd_cnt_q + CNT_W'(1);
    end

    assign timeout_c = busy_c && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            last_ls_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            rdata_q    <= '0;
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            ls_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            last_ls_q  <= last_ls_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            rdata_q    <= rdata_d;
            if_valid_q <= if_valid_d;
            ls_valid_q <= ls_valid_d;
            if_err_q   <= if_err_d;
            ls_err_q   <= ls_err_d;
        end
    end

    // Responses are dropped when the owning request was withdrawn mid-transfer
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        last_ls_d  = last_ls_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        rdata_d    = rdata_q;
        if_valid_d = 1'b0;
        ls_valid_d = 1'b0;
        if_err_d   = 1'b0;
        ls_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_if_c || grant_ls_c) begin
                    last_ls_d = grant_ls_c;
                    if (al_misalign) begin
                        state_d    = RESP;
                        rdata_d    = '0;
                        if_valid_d = grant_if_c;
                        ls_valid_d = grant_ls_c;
                        if_err_d   = grant_if_c;
                        ls_err_d   = grant_ls_c;
                    end else begin
                        state_d       = grant_ls_c ? BUSY_LS : BUSY_IF;
                        mem_req_d     = 1'b1;
                        mem_we_d      = al_we;
                        cmd_d.fetch   = grant_if_c;
                        cmd_d.ls_type = ls_type;
                        cmd_d.be      = al_be;
                        cmd_d.addr    = al_addr;
                        cmd_d.wdata   = al_wdata;
                    end
                end
            end
            BUSY_IF, BUSY_LS: begin
                if (mem_ack) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    rdata_d    = al_rdata;
                    if_valid_d = (state_q == BUSY_IF) && if_req;
                    ls_valid_d = (state_q == BUSY_LS) && ls_req;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (timeout_c) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    rdata_d    = '0;
                    if_valid_d = (state_q == BUSY_IF) && if_req;
                    ls_valid_d = (state_q == BUSY_LS) && ls_req;
                    if_err_d   = if_valid_d;
                    ls_err_d   = ls_valid_d;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign if_rdata   = rdata_q;
    assign ls_rdata   = rdata_q;
    assign if_valid   = if_valid_q;
    assign ls_valid   = ls_valid_q;
    assign if_err     = if_err_q;
    assign ls_err     = ls_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = {cmd_q.addr[XLEN-1:2], 2'b00};
    assign mem_wdata  = cmd_q.wdata;
    assign mem_be     = cmd_q.be;
    assign core_stall = (if_req | ls_req) & ~(if_valid_q | ls_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic against a byte-level memory model. Honours MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

    logic        clk, rst;
    logic        if_req, if_valid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_valid, ls_err;
    logic [2:0]  ls_type;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_req, mem_we, mem_ack, core_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int vectors = 0;
    int miscompares = 0;

    bit resp_on = 1'b1;
    int ack_lat_max = 0;
    int wait_left = 0;

    logic [31:0] dmem      [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_type(ls_type), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_valid(ls_valid), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .core_stall(core_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] dflt(input logic [31:0] wa);
        return (wa * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] dmem_rd(input logic [31:0] wa);
        return dmem.exists(wa) ? dmem[wa] : dflt(wa);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] wa);
        return model_mem.exists(wa) ? model_mem[wa] : dflt(wa);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory slave: acks after a random 0..ack_lat_max wait, applies byte-enabled writes
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            logic [31:0] w;
            @(posedge clk);
            #2;
            if (resp_on) begin
                mem_ack = 1'b0;
                if (mem_req) begin
                    if (wait_left == 0) begin
                        mem_ack   = 1'b1;
                        mem_rdata = dmem_rd(mem_addr);
                        if (mem_we) begin
                            w = dmem_rd(mem_addr);
                            for (int b = 0; b < 4; b++)
                                if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                            dmem[mem_addr] = w;
                        end
                        wait_left = $urandom_range(ack_lat_max);
                    end else begin
                        wait_left--;
                    end
                end
            end
        end
    end

    // Continuous protocol checks: single response, stable bus, stall definition
    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [68:0] prev_bus = '0;
    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if (core_stall !== ((if_req | ls_req) & ~(if_valid | ls_valid))) begin
                miscompares++;
                $display("FAIL core_stall: got %b with if_req=%b ls_req=%b if_valid=%b ls_valid=%b",
                         core_stall, if_req, ls_req, if_valid, ls_valid);
            end
            vectors++;
            if (if_valid && ls_valid) begin
                miscompares++;
                $display("FAIL dual_valid: if_valid=%b ls_valid=%b, expected at most one", if_valid, ls_valid);
            end
            if (prev_req && mem_req && !prev_ack) begin
                vectors++;
                if ({mem_we, mem_be, mem_addr, mem_wdata} !== prev_bus) begin
                    miscompares++;
                    $display("FAIL bus_stable: got %h expected %h", {mem_we, mem_be, mem_addr, mem_wdata}, prev_bus);
                end
            end
        end
        prev_req = mem_req;
        prev_ack = mem_ack;
        prev_bus = {mem_we, mem_be, mem_addr, mem_wdata};
    end

    // Reference model: RV32 load/store semantics on a byte-addressed memory
    task automatic model_ls(input logic we, input logic [2:0] t, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int unsigned sz, off;
        logic legal;
        logic [31:0] wa, word, val;
        legal = we ? (t <= 3'd2) : (t != 3'd3 && t <= 3'd5);
        sz    = 1 << t[1:0];
        er    = !legal || (a % sz != 0);
        rd    = '0;
        if (!er) begin
            wa   = a & ~32'h3;
            off  = a % 4;
            word = model_rd(wa);
            if (we) begin
                for (int i = 0; i < int'(sz); i++) word[8*(int'(off)+i) +: 8] = wd[8*i +: 8];
                model_mem[wa] = word;
            end else begin
                val = word >> (8 * off);
                if (sz == 1) begin
                    val = val & 32'hFF;
                    if (!t[2] && val >= 128) val = val - 32'd256;
                end else if (sz == 2) begin
                    val = val & 32'hFFFF;
                    if (!t[2] && val >= 32768) val = val - 32'd65536;
                end
                rd = val;
            end
        end
    endtask

    task automatic do_ls(input logic we, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er, output bit ok);
        ls_req = 1'b1; ls_we = we; ls_type = t; ls_addr = a; ls_wdata = wd;
        ok = 1'b0; rd = 'x; er = 'x;
        for (int c = 0; c < 300 && !ok; c++) begin
            tick();
            if (ls_valid) begin rd = ls_rdata; er = ls_err; ok = 1'b1; end
        end
        ls_req = 1'b0;
    endtask

    task automatic do_if(input logic [31:0] a, output logic [31:0] rd, output logic er, output bit ok);
        if_req = 1'b1; if_addr = a;
        ok = 1'b0; rd = 'x; er = 'x;
        for (int c = 0; c < 300 && !ok; c++) begin
            tick();
            if (if_valid) begin rd = if_rdata; er = if_err; ok = 1'b1; end
        end
        if_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({mem_req, mem_we, if_valid, ls_valid, if_err, ls_err, core_stall} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {mem_req, mem_we, if_valid, ls_valid, if_err, ls_err, core_stall});
        end
        vectors++;
        if ({mem_be, mem_addr, mem_wdata} !== 68'h0) begin
            miscompares++;
            $display("FAIL reset_bus: be=%h addr=%h wdata=%h expected 0", mem_be, mem_addr, mem_wdata);
        end
        vectors++;
        if ({if_rdata, ls_rdata} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: if=%h ls=%h expected 0", if_rdata, ls_rdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_conflict();
        logic [31:0] addrs[$];
        int order[$];
        logic [31:0] if_rd, ls_rd;
        logic was_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        wait_left = 0; ack_lat_max = 0;
        if_req = 1'b1; if_addr = 32'h104;
        ls_req = 1'b1; ls_we = 1'b0; ls_type = 3'b010; ls_addr = 32'h200;
        for (int c = 0; c < 40 && (if_req || ls_req); c++) begin
            tick();
            if (mem_req && !was_req) addrs.push_back(mem_addr);
            was_req = mem_req;
            if (ls_valid) begin order.push_back(1); ls_rd = ls_rdata; ls_req = 1'b0; end
            if (if_valid) begin order.push_back(0); if_rd = if_rdata; if_req = 1'b0; end
        end
        vectors++;
        if (addrs.size() != 2 || order.size() != 2) begin
            miscompares++;
            $display("FAIL conflict_count: %0d mem requests, %0d responses, expected 2 and 2",
                     addrs.size(), order.size());
        end else begin
            vectors++;
            if (addrs[0] !== 32'h200 || addrs[1] !== 32'h104) begin
                miscompares++;
                $display("FAIL conflict_addr: got %h,%h expected 00000200,00000104", addrs[0], addrs[1]);
            end
            vectors++;
            if (order[0] != 1 || order[1] != 0) begin
                miscompares++;
                $display("FAIL conflict_order: got %0d,%0d expected 1,0 (LS first)", order[0], order[1]);
            end
            vectors++;
            if (ls_rd !== model_rd(32'h200) || if_rd !== model_rd(32'h104)) begin
                miscompares++;
                $display("FAIL conflict_data: ls=%h if=%h expected %h %h",
                         ls_rd, if_rd, model_rd(32'h200), model_rd(32'h104));
            end
        end
        tick();
    endtask

    task automatic test_if_fetch();
        dmem[32'h100] = 32'h0050_0093;
        model_mem[32'h100] = 32'h0050_0093;
        wait_left = 0; ack_lat_max = 0;
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || if_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL if_issue: mem_req=%b addr=%h we=%b valid=%b expected 1 00000100 0 0",
                     mem_req, mem_addr, mem_we, if_valid);
        end
        tick();
        vectors++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h0050_0093 || if_err !== 1'b0) begin
            miscompares++;
            $display("FAIL if_resp: valid=%b rdata=%h err=%b expected 1 00500093 0", if_valid, if_rdata, if_err);
        end
        if_req = 1'b0;
        tick();
        vectors++;
        if (if_valid !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL if_pulse: valid=%b mem_req=%b expected 0 0", if_valid, mem_req);
        end
    endtask

    task automatic test_lanes();
        logic [31:0] rd, mrd, exp_tab[4];
        logic er, mer;
        bit ok;
        logic [2:0] ty_tab[4];
        logic [31:0] ad_tab[4];
        wait_left = 0; ack_lat_max = 0;
        ls_req = 1'b1; ls_we = 1'b1; ls_type = 3'b000; ls_addr = 32'h203; ls_wdata = 32'h0000_00AB;
        tick();
        vectors++;
        if (mem_be !== 4'b1000 || mem_wdata !== 32'hABAB_ABAB || mem_we !== 1'b1 || mem_addr !== 32'h200) begin
            miscompares++;
            $display("FAIL sb_lane: be=%b wdata=%h we=%b addr=%h expected 1000 abababab 1 00000200",
                     mem_be, mem_wdata, mem_we, mem_addr);
        end
        tick();
        vectors++;
        if (ls_valid !== 1'b1 || ls_err !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_resp: valid=%b err=%b expected 1 0", ls_valid, ls_err);
        end
        ls_req = 1'b0;
        model_ls(1'b1, 3'b000, 32'h203, 32'hAB, mrd, mer);
        tick();
        vectors++;
        if (dmem_rd(32'h200) !== model_rd(32'h200)) begin
            miscompares++;
            $display("FAIL sb_mem: got %h expected %h", dmem_rd(32'h200), model_rd(32'h200));
        end
        dmem[32'h200] = 32'h8012_3456;
        model_mem[32'h200] = 32'h8012_3456;
        ty_tab  = '{3'b000, 3'b100, 3'b001, 3'b101};
        ad_tab  = '{32'h203, 32'h203, 32'h202, 32'h202};
        exp_tab = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8012, 32'h0000_8012};
        for (int i = 0; i < 4; i++) begin
            do_ls(1'b0, ty_tab[i], ad_tab[i], 32'h0, rd, er, ok);
            vectors++;
            if (!ok || rd !== exp_tab[i] || er !== 1'b0) begin
                miscompares++;
                $display("FAIL load_ext[%0d]: ok=%0d rdata=%h err=%b expected %h 0", i, ok, rd, er, exp_tab[i]);
            end
        end
        tick();
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic er;
        bit ok;
        ls_req = 1'b1; ls_we = 1'b0; ls_type = 3'b010; ls_addr = 32'h202;
        tick();
        vectors++;
        if (ls_valid !== 1'b1 || ls_err !== 1'b1 || ls_rdata !== 32'h0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_misalign: valid=%b err=%b rdata=%h mem_req=%b expected 1 1 0 0",
                     ls_valid, ls_err, ls_rdata, mem_req);
        end
        ls_req = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'h102;
        tick();
        vectors++;
        if (if_valid !== 1'b1 || if_err !== 1'b1 || if_rdata !== 32'h0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL if_misalign: valid=%b err=%b rdata=%h mem_req=%b expected 1 1 0 0",
                     if_valid, if_err, if_rdata, mem_req);
        end
        if_req = 1'b0;
        tick();
        do_ls(1'b1, 3'b001, 32'h201, 32'h1234, rd, er, ok);
        vectors++;
        if (!ok || er !== 1'b1) begin
            miscompares++;
            $display("FAIL sh_misalign: ok=%0d err=%b expected 1", ok, er);
        end
        do_ls(1'b0, 3'b011, 32'h200, 32'h0, rd, er, ok);
        vectors++;
        if (!ok || er !== 1'b1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL bad_type: ok=%0d err=%b rdata=%h expected 1 0", ok, er, rd);
        end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        resp_on = 1'b0;
        mem_ack = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_type = 3'b010; ls_addr = 32'h300;
        tick();
        tick();
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_hold: mem_req=%b expected 1", mem_req);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || ls_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_rst: mem_req=%b ls_valid=%b expected 0 0", mem_req, ls_valid);
        end
        ls_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (ls_valid !== 1'b0 || if_valid !== 1'b0 || mem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL stray_ack[%0d]: ls_valid=%b if_valid=%b mem_req=%b expected 0 0 0",
                         c, ls_valid, if_valid, mem_req);
            end
            tick();
        end
        resp_on = 1'b1;
        wait_left = 0;
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        bit got = 1'b0;
        resp_on = 1'b0;
        mem_ack = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_type = 3'b010; ls_addr = 32'h300;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (mem_req) req_cycles++;
            if (ls_valid) got = 1'b1;
        end
        vectors++;
        if (!got || req_cycles != 4 || ls_err !== 1'b1 || ls_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL timeout: valid=%0d req_cycles=%0d err=%b rdata=%h expected 1 4 1 0",
                     got, req_cycles, ls_err, ls_rdata);
        end
`else
        for (int c = 0; c < 100; c++) begin
            tick();
            if (mem_req) req_cycles++;
            if (ls_valid) got = 1'b1;
        end
        vectors++;
        if (got || req_cycles != 100) begin
            miscompares++;
            $display("FAIL no_timeout: valid_seen=%0d req_cycles=%0d expected 0 100", got, req_cycles);
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        vectors++;
        if (ls_valid !== 1'b1 || ls_err !== 1'b0 || ls_rdata !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL late_ack: valid=%b err=%b rdata=%h expected 1 0 cafef00d", ls_valid, ls_err, ls_rdata);
        end
`endif
        ls_req = 1'b0;
        tick();
        resp_on = 1'b1;
        wait_left = 0;
    endtask

    task automatic test_random();
        ack_lat_max = 3;
        fork
            begin
                logic [31:0] a, rd, exp_rd;
                logic er, exp_er;
                bit ok;
                for (int n = 0; n < 60; n++) begin
                    a = 32'h1000 | ($urandom & 32'hFC);
                    if ($urandom_range(7) == 0) a = a | 32'($urandom_range(3, 1));
                    exp_er = (a % 4 != 0);
                    exp_rd = exp_er ? 32'h0 : model_rd(a);
                    do_if(a, rd, er, ok);
                    vectors++;
                    if (!ok || rd !== exp_rd || er !== exp_er) begin
                        miscompares++;
                        $display("FAIL rnd_if[%0d] addr=%h: ok=%0d rdata=%h err=%b expected %h %b",
                                 n, a, ok, rd, er, exp_rd, exp_er);
                    end
                    repeat ($urandom_range(2)) tick();
                end
            end
            begin
                logic [31:0] a, wd, rd, exp_rd;
                logic [2:0] t;
                logic we, er, exp_er;
                bit ok;
                for (int n = 0; n < 80; n++) begin
                    a  = 32'($urandom_range(63));
                    t  = 3'($urandom_range(7));
                    we = 1'($urandom_range(1));
                    wd = $urandom;
                    model_ls(we, t, a, wd, exp_rd, exp_er);
                    do_ls(we, t, a, wd, rd, er, ok);
                    vectors++;
                    if (!ok || er !== exp_er || (!we && rd !== exp_rd)) begin
                        miscompares++;
                        $display("FAIL rnd_ls[%0d] we=%b type=%0d addr=%h: ok=%0d rdata=%h err=%b expected %h %b",
                                 n, we, t, a, ok, rd, er, exp_rd, exp_er);
                    end
                    repeat ($urandom_range(2)) tick();
                end
            end
        join
        repeat (3) tick();
        foreach (model_mem[k]) begin
            vectors++;
            if (dmem_rd(k) !== model_mem[k]) begin
                miscompares++;
                $display("FAIL rnd_mem[%h]: got %h expected %h", k, dmem_rd(k), model_mem[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_type = '0; ls_addr = '0; ls_wdata = '0;
        test_reset();
        test_conflict();
        test_if_fetch();
        test_lanes();
        test_misalign();
        test_reset_mid_busy();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
